down_timer: RTL and testbench
=============================

Name: down_timer

Overview:
- Synchronous, loadable, programmable down-counter/timer; the counting-down counterpart to the team's ripple up-counter.
- A load handshake accepts a start value; the block decrements on each enabled clock and pulses terminal count on reaching zero.
- Optional auto-reload gives a periodic tick, so the block also serves as a clock-enable divider.
- All state is clocked on clk; there are no derived or rippled clocks.

Parameters:
WIDTH, 4, width of the count and load value
TCW, 8, width of the saturating terminal-count event counter

Ports:
clk  input  1  clock; all state updates on rising edge
rstn  input  1  asynchronous, active-low reset
load_valid  input  1  load request; load_value is valid while high
load_ready  output  1  block can accept a load; equals (state==IDLE)
load_value  input  WIDTH  start value, captured on handshake
auto_reload  input  1  sampled on handshake; 1 = periodic mode
en  input  1  count enable; count holds when low
abort  input  1  cancels a running count
count  output  WIDTH  current count, registered
busy  output  1  high in RUN
tc_pulse  output  1  one-cycle registered pulse on terminal count
tc_events  output  TCW  terminal counts since last load; saturates at all-ones

Behaviour:
- Reset (rstn low, async): state=IDLE, count=0, busy=0, tc_pulse=0, tc_events=0, reload_reg=0, mode_reg=0.
  - load_ready reads 1 during reset, but no handshake completes while rstn is low.
- Handshake: transfer occurs on a rising edge with load_valid && load_ready. Holding load_valid in IDLE reloads on every edge.
- FSM states: IDLE, RUN.
- IDLE, on transfer:
  - Captures reload_reg=load_value and mode_reg=auto_reload, and clears tc_events.
  - load_value!=0: count<=load_value, go to RUN.
  - load_value==0: count stays 0, tc_pulse=1 for the following cycle, tc_events<=1, stay in IDLE. Auto-reload is ignored for a zero load, so there is no infinite tick.
- IDLE, otherwise: count, tc_pulse=0, tc_events all hold.
- RUN, en=1 and count>1: count<=count-1.
- RUN, en=1 and count==1 (terminal edge): tc_pulse<=1 and tc_events increments (saturating). Then:
  - mode_reg=1: count<=reload_reg, stay in RUN.
  - mode_reg=0: count<=0, go to IDLE.
- RUN, en=0: count holds, tc_pulse=0.
- RUN, abort=1: go to IDLE, count<=0, tc_pulse=0, tc_events holds.
  - abort has priority over en and over the terminal edge; an abort at count==1 produces no pulse.
- abort in IDLE has no effect; a simultaneous load in IDLE is still accepted.
- Latency: load at edge N of value V with en held high gives count=V after edge N and count=0 with tc_pulse=1 after edge N+V. Single-shot: load_ready=1 again in that same cycle.
- Auto-reload period is exactly V enabled cycles per tc_pulse. tc_pulse never stays high for 2 consecutive cycles unless V==1 (then high every enabled cycle).
- Arithmetic:
  - count is unsigned WIDTH bits and never wraps below 0; the decrement never occurs from 0.
  - Max load 2^WIDTH-1 (15 at default) gives 15 cycles.
  - tc_events holds at 2^TCW-1.
- busy = (state==RUN); load_ready = !busy. Both are combinational from the state register only; no input-to-output combinational paths.
- Mid-operation async reset: returns to the reset values immediately; no tc_pulse.

Decomposition:
- Package down_timer_pkg:
  - state enum (IDLE, RUN)
  - default WIDTH/TCW localparams
  - TC_SAT constant helper
- One natural sub-module, sat_counter: TCW-bit saturating incrementer with sync clear and async reset, used for tc_events.
- FSM and count datapath stay in the top module.

Test Plan:
- Reset then idle: rstn low 3 cycles, release -> count=0, busy=0, load_ready=1, tc_pulse=0, tc_events=0.
- Single-shot: load 5, auto_reload=0, en=1 -> count 5,4,3,2,1,0 on successive cycles; tc_pulse high exactly one cycle (with count=0); busy drops same cycle; tc_events=1.
- Auto-reload and enable gaps: load 3, auto_reload=1, en toggled 1,0,1,1,1,1,1 -> count 3,2,2,1,3(tc),2,1,3(tc); tc_events=2.
- Abort priority: load 4, run to count==1, assert abort together with en -> count=0, IDLE, no tc_pulse, tc_events unchanged.
- Zero load and max load: load 0 -> tc_pulse one cycle, stays IDLE; load 15 (WIDTH=4) -> tc_pulse exactly 15 enabled cycles after load.
- Saturation and reset mid-run: TCW=2, load 1 auto-reload for 6 cycles -> tc_events sticks at 3; assert rstn mid-run -> all outputs zero asynchronously, load_ready=1 after release.

Source files
------------

// File: rtl/down_timer_pkg.sv
// Shared types and defaults for the loadable down-counter/timer.
package down_timer_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_TCW   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // All-ones value of a w-bit field: the saturation ceiling of an event counter.
  function automatic logic [31:0] tc_sat(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear and asynchronous reset.
module sat_counter
  import down_timer_pkg::*;
#(
  parameter int W = DEF_TCW
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] SAT = W'(tc_sat(W));
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] q_q, q_d;

  // A clear coinciding with an event leaves exactly that one event counted.
  always_comb begin
    q_d = q_q;
    if (clr)
      q_d = inc ? ONE : '0;
    else if (inc && (q_q != SAT))
      q_d = q_q + ONE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/down_timer.sv
// Loadable down-counter with terminal-count pulse, optional auto-reload and abort.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TCW   = DEF_TCW
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc_pulse,
  output logic [TCW-1:0]   tc_events
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             tc_pulse_q, tc_pulse_d;
  logic             ev_clr, ev_inc;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    mode_d     = mode_q;
    tc_pulse_d = 1'b0;
    ev_clr     = 1'b0;
    ev_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          reload_d = load_value;
          mode_d   = auto_reload;
          ev_clr   = 1'b1;
          if (load_value != '0) begin
            count_d = load_value;
            state_d = RUN;
          end else begin
            // Zero load terminates at once and never enters RUN, so no endless tick.
            count_d    = '0;
            tc_pulse_d = 1'b1;
            ev_inc     = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
        end else if (en) begin
          if (count_q == ONE) begin
            tc_pulse_d = 1'b1;
            ev_inc     = 1'b1;
            if (mode_q) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = IDLE;
            end
          end else begin
            count_d = count_q - ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      count_q    <= '0;
      reload_q   <= '0;
      mode_q     <= 1'b0;
      tc_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      mode_q     <= mode_d;
      tc_pulse_q <= tc_pulse_d;
    end
  end

  sat_counter #(.W(TCW)) u_tc_events (
    .clk  (clk),
    .rstn (rstn),
    .clr  (ev_clr),
    .inc  (ev_inc),
    .q    (tc_events)
  );

  assign busy       = (state_q == RUN);
  assign load_ready = !busy;
  assign count      = count_q;
  assign tc_pulse   = tc_pulse_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer (WIDTH=4, TCW=2 so saturation is reachable).
module tb_down_timer;

  localparam int WIDTH = 4;
  localparam int TCW   = 2;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic [WIDTH-1:0] load_value = '0;
  logic             auto_reload = 1'b0;
  logic             en = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc_pulse;
  logic [TCW-1:0]   tc_events;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  down_timer #(.WIDTH(WIDTH), .TCW(TCW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_value  (load_value),
    .auto_reload (auto_reload),
    .en          (en),
    .abort       (abort),
    .count       (count),
    .busy        (busy),
    .tc_pulse    (tc_pulse),
    .tc_events   (tc_events)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v, input logic ar);
    load_valid  = 1'b1;
    load_value  = v;
    auto_reload = ar;
    tick();
    load_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    tests++;
    if (load_ready !== 1'b1) begin fails++; $display("FAIL reset_load_ready got=%b exp=1", load_ready); end
    rstn = 1'b1;
    tick();
    tests++;
    if ({count, busy, load_ready, tc_pulse, tc_events} !== {4'd0, 1'b0, 1'b1, 1'b0, 2'd0}) begin
      fails++;
      $display("FAIL reset_idle count=%0d busy=%b ready=%b tc=%b ev=%0d exp 0/0/1/0/0",
               count, busy, load_ready, tc_pulse, tc_events);
    end
  endtask

  task automatic test_single_shot();
    en = 1'b1;
    do_load(4'd5, 1'b0);
    tests++;
    if (count !== 4'd5 || busy !== 1'b1 || load_ready !== 1'b0) begin
      fails++; $display("FAIL single_load count=%0d busy=%b ready=%b exp 5/1/0", count, busy, load_ready);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      tests++;
      if (count !== 4'(5 - k) || tc_pulse !== (k == 5) || busy !== (k != 5)) begin
        fails++;
        $display("FAIL single_step%0d count=%0d tc=%b busy=%b exp %0d/%b/%b",
                 k, count, tc_pulse, busy, 5 - k, (k == 5), (k != 5));
      end
    end
    tests++;
    if (tc_events !== 2'd1 || load_ready !== 1'b1) begin
      fails++; $display("FAIL single_events ev=%0d ready=%b exp 1/1", tc_events, load_ready);
    end
    tick();
    tests++;
    if (tc_pulse !== 1'b0 || count !== 4'd0) begin
      fails++; $display("FAIL single_after tc=%b count=%0d exp 0/0", tc_pulse, count);
    end
  endtask

  task automatic test_auto_reload();
    logic [6:0] en_pat = 7'b1111101;
    logic [3:0] exp_cnt [7] = '{4'd2, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
    logic       exp_tc  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    en = 1'b0;
    do_load(4'd3, 1'b1);
    tests++;
    if (count !== 4'd3) begin fails++; $display("FAIL auto_load count=%0d exp 3", count); end
    for (int k = 0; k < 7; k++) begin
      en = en_pat[k];
      tick();
      tests++;
      if (count !== exp_cnt[k] || tc_pulse !== exp_tc[k] || busy !== 1'b1) begin
        fails++;
        $display("FAIL auto_step%0d count=%0d tc=%b busy=%b exp %0d/%b/1",
                 k, count, tc_pulse, busy, exp_cnt[k], exp_tc[k]);
      end
    end
    tests++;
    if (tc_events !== 2'd2) begin fails++; $display("FAIL auto_events ev=%0d exp 2", tc_events); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || count !== 4'd0 || tc_events !== 2'd2) begin
      fails++; $display("FAIL auto_abort busy=%b count=%0d ev=%0d exp 0/0/2", busy, count, tc_events);
    end
  endtask

  task automatic test_abort();
    en = 1'b1;
    do_load(4'd4, 1'b0);
    repeat (3) tick();
    tests++;
    if (count !== 4'd1) begin fails++; $display("FAIL abort_pre count=%0d exp 1", count); end
    abort = 1'b1;
    tick();
    tests++;
    if (count !== 4'd0 || busy !== 1'b0 || tc_pulse !== 1'b0 || tc_events !== 2'd0) begin
      fails++;
      $display("FAIL abort_prio count=%0d busy=%b tc=%b ev=%0d exp 0/0/0/0", count, busy, tc_pulse, tc_events);
    end
    // abort held in IDLE must not block a load
    en = 1'b0;
    do_load(4'd2, 1'b0);
    abort = 1'b0;
    tests++;
    if (count !== 4'd2 || busy !== 1'b1) begin
      fails++; $display("FAIL abort_idle_load count=%0d busy=%b exp 2/1", count, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_zero_max();
    en = 1'b1;
    do_load(4'd0, 1'b1);
    tests++;
    if (tc_pulse !== 1'b1 || count !== 4'd0 || busy !== 1'b0 || tc_events !== 2'd1 || load_ready !== 1'b1) begin
      fails++;
      $display("FAIL zero_load tc=%b count=%0d busy=%b ev=%0d ready=%b exp 1/0/0/1/1",
               tc_pulse, count, busy, tc_events, load_ready);
    end
    tick();
    tests++;
    if (tc_pulse !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL zero_after tc=%b busy=%b exp 0/0", tc_pulse, busy);
    end
    do_load(4'd15, 1'b0);
    tests++;
    if (count !== 4'd15) begin fails++; $display("FAIL max_load count=%0d exp 15", count); end
    for (int k = 1; k <= 15; k++) begin
      tick();
      tests++;
      if (count !== 4'(15 - k) || tc_pulse !== (k == 15)) begin
        fails++;
        $display("FAIL max_step%0d count=%0d tc=%b exp %0d/%b", k, count, tc_pulse, 15 - k, (k == 15));
      end
    end
  endtask

  task automatic test_back_to_back();
    en = 1'b0;
    load_valid = 1'b1;
    load_value = 4'd0;
    auto_reload = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      tests++;
      if (tc_pulse !== 1'b1 || tc_events !== 2'd1 || busy !== 1'b0) begin
        fails++; $display("FAIL b2b_zero%0d tc=%b ev=%0d busy=%b exp 1/1/0", k, tc_pulse, tc_events, busy);
      end
    end
    load_value = 4'd6;
    tick();
    load_valid = 1'b0;
    tests++;
    if (count !== 4'd6 || busy !== 1'b1 || tc_pulse !== 1'b0 || tc_events !== 2'd0) begin
      fails++;
      $display("FAIL b2b_load count=%0d busy=%b tc=%b ev=%0d exp 6/1/0/0", count, busy, tc_pulse, tc_events);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_sat_reset();
    en = 1'b1;
    do_load(4'd1, 1'b1);
    tests++;
    if (count !== 4'd1 || tc_events !== 2'd0) begin
      fails++; $display("FAIL sat_load count=%0d ev=%0d exp 1/0", count, tc_events);
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      tests++;
      if (tc_pulse !== 1'b1 || count !== 4'd1 || tc_events !== 2'((k > 3) ? 3 : k)) begin
        fails++;
        $display("FAIL sat_step%0d tc=%b count=%0d ev=%0d exp 1/1/%0d", k, tc_pulse, count, tc_events, (k > 3) ? 3 : k);
      end
    end
    #2 rstn = 1'b0;
    #1;
    tests++;
    if ({count, busy, tc_pulse, tc_events, load_ready} !== {4'd0, 1'b0, 1'b0, 2'd0, 1'b1}) begin
      fails++;
      $display("FAIL async_reset count=%0d busy=%b tc=%b ev=%0d ready=%b exp 0/0/0/0/1",
               count, busy, tc_pulse, tc_events, load_ready);
    end
    load_valid = 1'b1;
    load_value = 4'd5;
    tick();
    load_valid = 1'b0;
    tests++;
    if (count !== 4'd0 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_no_load count=%0d busy=%b exp 0/0", count, busy);
    end
    rstn = 1'b1;
    tick();
    tests++;
    if (load_ready !== 1'b1 || count !== 4'd0 || tc_pulse !== 1'b0) begin
      fails++; $display("FAIL reset_release ready=%b count=%0d tc=%b exp 1/0/0", load_ready, count, tc_pulse);
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_auto_reload();
    test_abort();
    test_zero_max();
    test_back_to_back();
    test_sat_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
